// File: rtl/wb_sel_ctrl_if.sv
// Write-back request/grant and select-code bundle between the functional-unit
// side (master) and the write-back select controller (slave).
interface wb_sel_ctrl_if #(
    parameter int NSRC = 7,
    parameter int NREG = 16
);
    logic                  stall;
    logic [NSRC-1:0]       src_valid;
    logic [4*NSRC-1:0]     src_dest;
    logic [NSRC-1:0]       src_ready;
    logic [3*NREG-1:0]     sel_bus;
    logic [NREG-1:0]       reg_written;
    logic [2:0]            rr_ptr;

    modport master (
        output stall, src_valid, src_dest,
        input  src_ready, sel_bus, reg_written, rr_ptr
    );

    modport slave (
        input  stall, src_valid, src_dest,
        output src_ready, sel_bus, reg_written, rr_ptr
    );
endinterface

// File: rtl/wb_sel_ctrl.sv
// Write-back select controller: rotating-priority arbitration of seven sources
// onto sixteen state registers, producing registered 3-bit mux select codes.
module wb_sel_ctrl (
    input  logic          clk,
    input  logic          rst,
    wb_sel_ctrl_if.slave  bus
);
    localparam int NSRC = 7;
    localparam int NREG = 16;

    localparam logic [2:0]        CODE_HOLD = 3'd6;
    localparam logic [2:0]        CODE_SRAM = 3'd7;
    localparam logic [3*NREG-1:0] ALL_HOLD  = {NREG{CODE_HOLD}};

    logic [3*NREG-1:0] sel_q, sel_d;
    logic [NREG-1:0]   written_q, written_d;
    logic [2:0]        ptr_q, ptr_d;

    logic [NREG-1:0]   has_win;
    logic [NREG-1:0]   multi;
    logic [2:0]        win_src [NREG];
    logic [NSRC-1:0]   ready;
    logic [3:0]        scan_sum;
    logic [2:0]        scan_idx;
    logic [3:0]        dest;

    // Per-register scan starting at the pointer: first hit wins, any later hit
    // marks the register as contended so the pointer rotates.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves a latch.
        has_win  = '0;
        multi    = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int r = 0; r < NREG; r++) begin
            win_src[r] = '0;
        end
        for (int r = 0; r < NREG; r++) begin
            for (int k = 0; k < NSRC; k++) begin
                scan_sum = {1'b0, ptr_q} + 4'(k);
                scan_idx = (scan_sum >= 4'd7) ? 3'(scan_sum - 4'd7) : scan_sum[2:0];
                if (bus.src_valid[scan_idx] &&
                    bus.src_dest[4*scan_idx +: 4] == 4'(r)) begin
                    if (has_win[r]) begin
                        multi[r] = 1'b1;
                    end else begin
                        has_win[r] = 1'b1;
                        win_src[r] = scan_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        dest  = '0;
        for (int i = 0; i < NSRC; i++) begin
            dest     = bus.src_dest[4*i +: 4];
            ready[i] = bus.src_valid[i] && has_win[dest] &&
                       (win_src[dest] == 3'(i)) && !bus.stall && !rst;
        end
    end

    always_comb begin
        sel_d     = ALL_HOLD;
        written_d = '0;
        ptr_d     = ptr_q;
        if (!bus.stall) begin
            for (int r = 0; r < NREG; r++) begin
                if (has_win[r]) begin
                    sel_d[3*r +: 3] = (win_src[r] == 3'd6) ? CODE_SRAM : win_src[r];
                    written_d[r]    = 1'b1;
                end
            end
            if (|multi) begin
                ptr_d = (ptr_q == 3'd6) ? 3'd0 : ptr_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= ALL_HOLD;
            written_q <= '0;
            ptr_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values together.
            sel_q     <= sel_d;
            written_q <= written_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.src_ready   = ready;
    assign bus.sel_bus     = sel_q;
    assign bus.reg_written = written_q;
    assign bus.rr_ptr      = ptr_q;
endmodule

// File: tb/tb_wb_sel_ctrl.sv
// Self-checking bench for wb_sel_ctrl: directed scenarios plus randomized
// persistent requests compared against a distance-based arbitration model.
module tb_wb_sel_ctrl;
    logic clk;
    logic rst;

    wb_sel_ctrl_if #(.NSRC(7), .NREG(16)) bus ();

    wb_sel_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [47:0] ALL_HOLD = 48'o6666666666666666;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [2:0]  mdl_ptr;
    logic [6:0]  mdl_rdy;
    logic [6:0]  dut_rdy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Winner = valid source whose rotated distance from the pointer is strictly
    // smallest among sources targeting the same register.
    task automatic model(input logic [6:0] v, input logic [27:0] d, input logic st,
                         input logic [2:0] p, output logic [6:0] rdy,
                         output logic [47:0] sel, output logic [15:0] wr,
                         output logic [2:0] np);
        bit conflict = 0;
        int di, dj;
        rdy = '0;
        sel = ALL_HOLD;
        wr  = '0;
        for (int i = 0; i < 7; i++) begin
            for (int j = i + 1; j < 7; j++) begin
                if (v[i] && v[j] && d[4*i +: 4] == d[4*j +: 4]) conflict = 1;
            end
        end
        for (int i = 0; i < 7; i++) begin
            if (v[i] && !st) begin
                bit win = 1;
                di = (i - int'(p) + 7) % 7;
                for (int j = 0; j < 7; j++) begin
                    dj = (j - int'(p) + 7) % 7;
                    if (j != i && v[j] && d[4*j +: 4] == d[4*i +: 4] && dj < di) win = 0;
                end
                if (win) begin
                    rdy[i] = 1'b1;
                    sel[3*d[4*i +: 4] +: 3] = (i == 6) ? 3'd7 : 3'(i);
                    wr[d[4*i +: 4]] = 1'b1;
                end
            end
        end
        np = (conflict && !st) ? ((p == 3'd6) ? 3'd0 : p + 3'd1) : p;
    endtask

    // Called at posedge+1: drive, check grants mid-cycle, check registered outputs.
    task automatic step(input logic [6:0] v, input logic [27:0] d, input logic st);
        logic [47:0] s;
        logic [15:0] w;
        logic [2:0]  np;
        bus.src_valid = v;
        bus.src_dest  = d;
        bus.stall     = st;
        #2;
        model(v, d, st, mdl_ptr, mdl_rdy, s, w, np);
        dut_rdy = bus.src_ready;
        check("src_ready", 64'(dut_rdy), 64'(mdl_rdy));
        @(posedge clk);
        #1;
        mdl_ptr = np;
        check("sel_bus", 64'(bus.sel_bus), 64'(s));
        check("reg_written", 64'(bus.reg_written), 64'(w));
        check("rr_ptr", 64'(bus.rr_ptr), 64'(np));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         win_tbl [8] = '{0, 3, 3, 3, 6, 6, 6, 0};
        logic [6:0] seen;
        logic       req_v [7];
        logic [3:0] req_d [7];
        logic [6:0] v;
        logic [27:0] d;

        rst = 1'b1;
        bus.src_valid = '0;
        bus.src_dest  = '0;
        bus.stall     = 1'b0;
        mdl_ptr       = '0;
        #1;
        check("rst_sel", 64'(bus.sel_bus), 64'(ALL_HOLD));
        check("rst_wr", 64'(bus.reg_written), 64'h0);
        check("rst_ptr", 64'(bus.rr_ptr), 64'h0);
        check("rst_ready", 64'(bus.src_ready), 64'h0);
        #11 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int c = 0; c < 10; c++) step(7'h00, 28'h0, 1'b0);

        // Single write to register 5 from source 0.
        step(7'b0000001, 28'h0000005, 1'b0);
        check("single_rdy", 64'(dut_rdy), 64'h01);
        check("single_sel5", 64'(bus.sel_bus[17:15]), 64'h0);
        check("single_wr", 64'(bus.reg_written), 64'h0020);
        step(7'h00, 28'h0, 1'b0);
        check("single_hold", 64'(bus.sel_bus), 64'(ALL_HOLD));

        // Parallel: src2->3, src4->9, src6->15.
        step(7'b1010100, 28'hF090300, 1'b0);
        check("par_rdy", 64'(dut_rdy), 64'h54);
        check("par_sel3", 64'(bus.sel_bus[11:9]), 64'h2);
        check("par_sel9", 64'(bus.sel_bus[29:27]), 64'h4);
        check("par_sel15", 64'(bus.sel_bus[47:45]), 64'h7);
        check("par_wr", 64'(bus.reg_written), 64'h8208);
        check("par_ptr", 64'(bus.rr_ptr), 64'h0);

        // Conflict rotation: sources 0, 3, 6 all targeting register 7.
        seen = '0;
        for (int c = 0; c < 8; c++) begin
            step(7'b1001001, 28'h7777777, 1'b0);
            check("rot_winner", 64'(dut_rdy), 64'(7'b1 << win_tbl[c]));
            if (c < 7) seen |= dut_rdy;
        end
        check("rot_no_starve", 64'(seen), 64'h49);
        check("rot_ptr", 64'(bus.rr_ptr), 64'h1);

        // Stall three cycles with source 1 requesting register 2.
        for (int c = 0; c < 3; c++) begin
            step(7'b0000010, 28'h0000020, 1'b1);
            check("stall_rdy", 64'(dut_rdy), 64'h0);
            check("stall_hold", 64'(bus.sel_bus), 64'(ALL_HOLD));
        end
        step(7'b0000010, 28'h0000020, 1'b0);
        check("unstall_rdy", 64'(dut_rdy), 64'h02);
        check("unstall_sel2", 64'(bus.sel_bus[8:6]), 64'h1);

        // Randomized persistent requests: losers hold until granted.
        for (int i = 0; i < 7; i++) begin
            req_v[i] = 1'b0;
            req_d[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            v = '0;
            d = '0;
            for (int i = 0; i < 7; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) == 0) begin
                    req_v[i] = 1'b1;
                    req_d[i] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(0, 2));
                end
                v[i] = req_v[i];
                d[4*i +: 4] = req_v[i] ? req_d[i] : 4'($urandom_range(0, 15));
            end
            step(v, d, ($urandom_range(0, 7) == 0));
            for (int i = 0; i < 7; i++) begin
                if (mdl_rdy[i]) req_v[i] = 1'b0;
            end
        end

        // Asynchronous reset right after a grant edge, with a nonzero pointer.
        step(7'b0000011, 28'h0000044, 1'b0);
        step(7'b0000001, 28'h0000004, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sel", 64'(bus.sel_bus), 64'(ALL_HOLD));
        check("arst_wr", 64'(bus.reg_written), 64'h0);
        check("arst_ptr", 64'(bus.rr_ptr), 64'h0);
        check("arst_ready", 64'(bus.src_ready), 64'h0);
        bus.src_valid = '0;
        #1 rst = 1'b0;
        mdl_ptr = '0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) step(7'b1000001, 28'h3000003, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
